// File: rtl/cla_seq_pkg.sv
// ============================================================================
// Module   : cla_seq_pkg
// Brief    : Shared state encoding and nibble width for the sequential CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_seq_state_t;

    localparam int NIBBLE_W = 4;

endpackage

`default_nettype wire

// File: rtl/cla_nibble_add.sv
// ============================================================================
// Module   : cla_nibble_add
// Brief    : Purely combinational 4-bit carry-lookahead adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_nibble_add
    import cla_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W-1:0] w_g;
    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is expanded down to ci so no term ripples through another.
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign co     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s = w_p ^ w_c;

endmodule

`default_nettype wire

// File: rtl/cla_nibble_seq.sv
// ============================================================================
// Module   : cla_nibble_seq
// Brief    : Multi-cycle WIDTH-bit adder time-sharing one 4-bit CLA nibble,
//            LSB nibble first. Optional subtract support: CLA_SEQ_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_nibble_seq
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(NIB);

    cla_seq_state_t r_state;
    cla_seq_state_t w_state_nxt;

    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic                r_carry;
    logic                r_cout;
    logic                r_ovf;
    logic [IDX_W-1:0]    r_idx;

    logic [WIDTH-1:0]    w_b_eff;
    logic                w_cin_eff;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_co;
    logic                w_accept;
    logic                w_last;
    logic [IDX_W+1:0]    w_base;

`ifdef CLA_SEQ_SUB_EN
    assign w_b_eff   = op ? ~b : b;
    assign w_cin_eff = op ? 1'b1 : cin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
`endif

    // Operands shift right each RUN cycle, so the active nibble is always bits [3:0].
    cla_nibble_add u_nibble_add (
        .a  (r_a[NIBBLE_W-1:0]),
        .b  (r_b[NIBBLE_W-1:0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_last = (r_idx == IDX_W'(NIB - 1));
    assign w_base = {r_idx, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[w_base +: NIBBLE_W] <= w_s;
            r_carry <= w_co;
            r_a     <= {{NIBBLE_W{1'b0}}, r_a[WIDTH-1:NIBBLE_W]};
            r_b     <= {{NIBBLE_W{1'b0}}, r_b[WIDTH-1:NIBBLE_W]};
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= (r_a[NIBBLE_W-1] == r_b[NIBBLE_W-1]) &&
                          (w_s[NIBBLE_W-1] != r_a[NIBBLE_W-1]);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cla_nibble_seq.sv
// ============================================================================
// Module   : tb_cla_nibble_seq
// Brief    : Directed self-checking bench for cla_nibble_seq (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_nibble_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int n_cmp;
    int n_fail;

    cla_nibble_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one operand pair, waits (bounded) for out_valid, returns the result.
    // With out_ready high the result is consumed and the FSM is back in IDLE on return.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          input logic top, output logic [15:0] s, output logic co,
                          output logic ov, output int lat);
        @(negedge clk);
        a        = ta;
        b        = tb_v;
        cin      = tc;
        op       = top;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        s  = sum;
        co = cout;
        ov = ovf;
        if (out_ready && out_valid) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b, want 1 0 0 0000 0 0",
                     in_ready, out_valid, busy, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vc [5];
        logic [15:0] es [5];
        logic        ec [5];
        logic        eo [5];
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        va = '{16'h1234, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
        vb = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h8000};
        vc = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0};
        es = '{16'h5555, 16'h0000, 16'h0001, 16'h8000, 16'h0000};
        ec = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
        eo = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b0, s, co, ov, lat);
            n_cmp++;
            if (s !== es[i] || co !== ec[i] || ov !== eo[i]) begin
                n_fail++;
                $display("FAIL add_%0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, s, co, ov, es[i], ec[i], eo[i]);
            end
            n_cmp++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL latency_%0d: got %0d cycles, want 4", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        out_ready = 1'b0;
        run_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, s, co, ov, lat);
        n_cmp++;
        if (s !== 16'h1000 || co !== 1'b0 || ov !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL hold_result: got sum=%h cout=%b ovf=%b lat=%0d, want 1000 0 0 4", s, co, ov, lat);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 3) begin
                a        = 16'hAAAA;
                b        = 16'h1111;
                cin      = 1'b1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                sum !== 16'h1000 || cout !== 1'b0 || ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle_%0d: got vld=%b rdy=%b busy=%b sum=%h cout=%b ovf=%b, want 1 0 1 1000 0 0",
                         k, out_valid, in_ready, busy, sum, cout, ovf);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, s, co, ov, lat);
        n_cmp++;
        if (s !== 16'h3333 || co !== 1'b0 || ov !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL after_release: got sum=%h cout=%b ovf=%b lat=%0d, want 3333 0 0 4", s, co, ov, lat);
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        out_ready = 1'b1;
        @(negedge clk);
        a        = 16'h1111;
        b        = 16'h1111;
        cin      = 1'b0;
        op       = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b, want 1 0 0 0000 0 0",
                     in_ready, out_valid, busy, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
        n_cmp++;
        if (s !== 16'h0002 || co !== 1'b0 || ov !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL post_reset_op: got sum=%h cout=%b ovf=%b lat=%0d, want 0002 0 0 4", s, co, ov, lat);
        end
    endtask

`ifdef CLA_SEQ_SUB_EN
    task automatic test_sub();
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          lat;
        out_ready = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, s, co, ov, lat);
        n_cmp++;
        if (s !== 16'hFFFE || co !== 1'b0 || ov !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL sub_5_7: got sum=%h cout=%b ovf=%b lat=%0d, want FFFE 0 0 4", s, co, ov, lat);
        end
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, s, co, ov, lat);
        n_cmp++;
        if (s !== 16'h7FFF || co !== 1'b1 || ov !== 1'b1 || lat !== 4) begin
            n_fail++;
            $display("FAIL sub_min_1: got sum=%h cout=%b ovf=%b lat=%0d, want 7FFF 1 1 4", s, co, ov, lat);
        end
    endtask
`endif

    // in_valid held high: accepts land 6 cycles apart (NIB + 2).
    task automatic test_back_to_back();
        int acc [$];
        int i5;
        out_ready = 1'b1;
        @(negedge clk);
        a        = 16'h0001;
        b        = 16'h0002;
        cin      = 1'b0;
        op       = 1'b0;
        in_valid = 1'b1;
        i5 = 0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) @(negedge clk);
            if (in_ready === 1'b1) acc.push_back(k);
            if (k == 5) begin
                n_cmp++;
                if (out_valid !== 1'b1 || sum !== 16'h0003) begin
                    n_fail++;
                    $display("FAIL b2b_result: got vld=%b sum=%h, want 1 0003", out_valid, sum);
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (acc.size() !== 3 || acc[0] !== 0 || acc[1] !== 6 || acc[2] !== 12) begin
            n_fail++;
            $display("FAIL b2b_interval: got %0d ready slots (first=%0d second=%0d), want slots 0,6,12",
                     acc.size(), (acc.size() > 0) ? acc[0] : -1, (acc.size() > 1) ? acc[1] : -1);
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_add();
        test_backpressure();
        test_reset_midop();
`ifdef CLA_SEQ_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
